// File: rtl/crc32_pkg.sv
// CRC-32 (ISO-HDLC / zlib) shared constants, FSM state type and keep-mask helper.
// Imported by crc32_byte_step and crc32_engine.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOR       = 32'hFFFFFFFF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // True when the low n bits of keep are 1..10..0 (MSB-aligned run of ones).
  function automatic logic keep_contig(input logic [7:0] keep, input int n);
    logic seen0;
    logic ok;
    seen0 = 1'b0;
    ok    = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (i < n) begin
        if (!keep[i]) seen0 = 1'b1;
        else if (seen0) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/crc32_engine_if.sv
// Beat-stream bundle for crc32_engine: start/val/dat/keep/lst in, busy/done/val/dat out.
// master = stream source (PNG chunk writer), slave = CRC engine.
interface crc32_engine_if #(
  parameter int DATA_WD = 32
);
  localparam int KEEP_WD = DATA_WD / 8;

  logic               start_i;
  logic               val_i;
  logic [DATA_WD-1:0] dat_i;
  logic [KEEP_WD-1:0] keep_i;
  logic               lst_i;
  logic               busy_o;
  logic               done_o;
  logic               val_o;
  logic [31:0]        dat_o;

  modport master (
    output start_i, val_i, dat_i, keep_i, lst_i,
    input  busy_o, done_o, val_o, dat_o
  );

  modport slave (
    input  start_i, val_i, dat_i, keep_i, lst_i,
    output busy_o, done_o, val_o, dat_o
  );

endinterface

// File: rtl/crc32_byte_step.sv
// One reflected CRC-32 byte update (8 LSB-first Galois steps); en_i=0 passes crc through.
// Ports: en_i, crc_i[31:0], byte_i[7:0] -> crc_o[31:0]. Purely combinational.
module crc32_byte_step
  import crc32_pkg::*;
(
  input  logic        en_i,
  input  logic [31:0] crc_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i;
    if (en_i) begin
      c = crc_i ^ {24'h0, byte_i};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
      end
    end
  end

  assign crc_o = c;

endmodule

// File: rtl/crc32_engine.sv
// Streaming CRC-32 over DATA_WD-bit beats (MSB byte first), partial last beat via keep_i.
// Ports: clk, rst (async high), bus (crc32_engine_if.slave). Option: CRC32_ENGINE_OUT_REG_EN.
module crc32_engine
  import crc32_pkg::*;
#(
  parameter int          DATA_WD  = 32,
  parameter logic [31:0] CRC_INIT = CRC32_INIT,
  parameter logic [31:0] CRC_XOR  = CRC32_XOR
) (
  input logic           clk,
  input logic           rst,
  crc32_engine_if.slave bus
);

  localparam int KEEP_WD = DATA_WD / 8;

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic        done_q, done_d;
  logic [31:0] dat_q, dat_d;
  logic        acc;
  logic [31:0] crc_next;

  logic [KEEP_WD:0][31:0] chain;

  assign acc = bus.val_i & ((state_q == RUN) | bus.start_i);

  // A start beat is seeded fresh, never from the (possibly aborted) register.
  assign chain[0] = bus.start_i ? CRC_INIT : crc_q;

  for (genvar k = 0; k < KEEP_WD; k++) begin : g_step
    crc32_byte_step u_step (
      .en_i   (~bus.lst_i | bus.keep_i[KEEP_WD-1-k]),
      .crc_i  (chain[k]),
      .byte_i (bus.dat_i[DATA_WD-1-8*k -: 8]),
      .crc_o  (chain[k+1])
    );
  end

  assign crc_next = chain[KEEP_WD];

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    done_d  = 1'b0;
    dat_d   = dat_q;
    if (bus.start_i) begin
      state_d = RUN;
      crc_d   = CRC_INIT;
    end
    if (acc) begin
      crc_d = crc_next;
      if (bus.lst_i) begin
        state_d = IDLE;
        crc_d   = CRC_INIT;
        done_d  = 1'b1;
        // Reflected register after XOR is the numeric CRC; [31:24] goes out first.
        dat_d   = crc_next ^ CRC_XOR;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      crc_q   <= CRC_INIT;
      done_q  <= 1'b0;
      dat_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      done_q  <= done_d;
      dat_q   <= dat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && acc && bus.lst_i) begin
      assert (keep_contig(8'(bus.keep_i), KEEP_WD));
    end
  end

  assign bus.busy_o = (state_q == RUN);

`ifdef CRC32_ENGINE_OUT_REG_EN
  logic        done2_q;
  logic [31:0] dat2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done2_q <= 1'b0;
      dat2_q  <= 32'h0;
    end else begin
      done2_q <= done_q;
      dat2_q  <= dat_q;
    end
  end

  assign bus.done_o = done2_q;
  assign bus.val_o  = done2_q;
  assign bus.dat_o  = dat2_q;
`else
  assign bus.done_o = done_q;
  assign bus.val_o  = done_q;
  assign bus.dat_o  = dat_q;
`endif

endmodule

// File: tb/tb_crc32_engine.sv
// Self-checking bench for crc32_engine: directed vectors plus random messages
// checked against an MSB-first (non-reflected) polynomial CRC-32 model.
module tb_crc32_engine;

  localparam int DATA_WD = 32;
  localparam int KEEP_WD = DATA_WD / 8;
`ifdef CRC32_ENGINE_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  crc32_engine_if #(.DATA_WD(DATA_WD)) bus ();

  crc32_engine #(.DATA_WD(DATA_WD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int val_bad = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [7:0]  msg[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.val_o !== bus.done_o) val_bad++;
      if (bus.done_o === 1'b1) got_q.push_back(bus.dat_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  // Textbook CRC-32: reflect input bytes, MSB-first division by 0x04C11DB7,
  // reflect result, final XOR.
  function automatic logic [31:0] ref_crc();
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    foreach (msg[i]) begin
      r = r ^ {rev8(msg[i]), 24'h0};
      repeat (8) r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
    end
    return rev32(r) ^ 32'hFFFFFFFF;
  endfunction

  function automatic logic [DATA_WD-1:0] rnd_dat();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DATA_WD-1:0];
  endfunction

  task automatic cyc(input logic s, input logic v, input logic l,
                     input logic [DATA_WD-1:0] d,
                     input logic [KEEP_WD-1:0] k);
    bus.start_i = s;
    bus.val_i   = v;
    bus.lst_i   = l;
    bus.dat_i   = d;
    bus.keep_i  = k;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic set_str(input string s);
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
  endtask

  task automatic send_msg();
    int n;
    int nb;
    logic [DATA_WD-1:0] d;
    logic [KEEP_WD-1:0] k;
    logic last;
    n  = msg.size();
    nb = (n == 0) ? 1 : (n + KEEP_WD - 1) / KEEP_WD;
    for (int b = 0; b < nb; b++) begin
      d = rnd_dat();
      k = '0;
      for (int j = 0; j < KEEP_WD; j++) begin
        if (b * KEEP_WD + j < n) begin
          d[DATA_WD-1-8*j -: 8] = msg[b*KEEP_WD+j];
          k[KEEP_WD-1-j] = 1'b1;
        end
      end
      last = (b == nb - 1);
      if (!last) k = KEEP_WD'($urandom());
      cyc(b == 0, 1'b1, last, d, k);
      chk("busy_in_msg", {31'b0, bus.busy_o}, {31'b0, !last});
    end
    exp_q.push_back(ref_crc());
  endtask

  task automatic drain(input string tag, input bit use_lit,
                       input logic [31:0] lit);
    logic [31:0] g;
    repeat (LAT + 2) idle();
    chk($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
    chk($sformatf("%s_val_o", tag), 32'(val_bad), 32'd0);
    if (use_lit) begin
      g = (got_q.size() > 0) ? got_q[0] : 32'hxxxxxxxx;
      chk($sformatf("%s_vector", tag), g, lit);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      chk($sformatf("%s_crc", tag), got_q.pop_front(), exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
    val_bad = 0;
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.val_i   = 1'b0;
    bus.lst_i   = 1'b0;
    bus.dat_i   = '0;
    bus.keep_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, bus.busy_o}, 32'd0);
    chk("rst_done", {31'b0, bus.done_o}, 32'd0);
    chk("rst_val", {31'b0, bus.val_o}, 32'd0);
    chk("rst_dat", bus.dat_o, 32'd0);
    rst = 1'b0;
    idle();

    // IEND, with exact latency
    set_str("IEND");
    send_msg();
    chk("lat_edge1", {31'b0, bus.done_o}, {31'b0, LAT == 1});
    idle();
    chk("lat_edge2", {31'b0, bus.done_o}, {31'b0, LAT == 2});
    drain("iend", 1'b1, 32'hAE426082);

    // check string, partial last beat
    set_str("123456789");
    send_msg();
    drain("check", 1'b1, 32'hCBF43926);

    // empty message
    msg.delete();
    send_msg();
    drain("empty", 1'b1, 32'h00000000);

    // back-to-back, no idle cycles
    set_str("IEND");
    send_msg();
    set_str("123456789");
    send_msg();
    set_str("IEND");
    send_msg();
    drain("b2b", 1'b0, 32'h0);

    // abort with start_i after first beat
    cyc(1'b1, 1'b1, 1'b0, 32'h31323334, 4'hF);
    set_str("IEND");
    send_msg();
    drain("abort", 1'b1, 32'hAE426082);

    // val_i / lst_i in IDLE without start are ignored
    cyc(1'b0, 1'b1, 1'b1, rnd_dat(), '1);
    cyc(1'b0, 1'b0, 1'b1, rnd_dat(), '1);
    drain("idle_ign", 1'b0, 32'h0);

    // reset mid-message
    cyc(1'b1, 1'b1, 1'b0, 32'h31323334, 4'hF);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_busy", {31'b0, bus.busy_o}, 32'd0);
    chk("mrst_done", {31'b0, bus.done_o}, 32'd0);
    chk("mrst_val", {31'b0, bus.val_o}, 32'd0);
    chk("mrst_dat", bus.dat_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 1'b1, 1'b1, 32'h35363738, 4'hF);
    drain("mrst", 1'b0, 32'h0);
    set_str("IEND");
    send_msg();
    drain("post_rst", 1'b1, 32'hAE426082);

    // random messages with random gaps
    for (int m = 0; m < 30; m++) begin
      int len;
      int gap;
      len = $urandom_range(0, 13);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom()));
      send_msg();
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        cyc(1'b0, 1'($urandom()), 1'($urandom()), rnd_dat(),
            KEEP_WD'($urandom()));
      end
    end
    drain("rand", 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
